// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: none (package only).
// Backpressure: none (package only).
package keypad_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } kp_state_t;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 4;
    localparam int ROW_W = 2;
    localparam int COL_W = 2;

    // Row drive with row 0 active, and column bus with no key pressed.
    localparam logic [ROWS-1:0] ROW_RST_N  = 4'b1110;
    localparam logic [COLS-1:0] COL_IDLE_N = 4'b1111;

    // Index of the lowest column pulled low; 0 when none are low.
    function automatic logic [COL_W-1:0] first_low(input logic [COLS-1:0] v);
        first_low = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!v[i]) first_low = COL_W'(i);
        end
    endfunction

    // Active-low one-cold drive for row r.
    function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] r);
        row_drive = ~(ROWS'(1) << r);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle enable pulse every TICK_DIV clocks.
// Latency: tick asserted while the counter sits at TICK_DIV-1.
// Backpressure: none; the pulse train never stalls.
// Ports: ck (clock), rst_n (async active-low reset), tick (enable pulse out).
module scan_tick_gen #(
    parameter int TICK_DIV = 131072
) (
    input  logic ck,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] div_cnt;

    assign tick = (div_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debounce and valid/ack key output.
// Latency: key_valid rises one clock after the tick that completes DEBOUNCE_SCANS matching scans.
// Backpressure: a key accepted while key_valid is unconsumed is dropped and flags sticky overrun.
// Ports: ck, rst_n (async active-low); col_n (async active-low columns in);
//        row_n (active-low row drive); key_code/key_valid/key_ack (key handshake);
//        key_down (key still held); overrun (sticky lost-key flag).
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int TICK_DIV       = 131072,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             key_down,
    output logic             overrun
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic             tick;
    logic [COLS-1:0]  col_m;
    logic [COLS-1:0]  col_s;
    logic             any_pressed;
    logic [COL_W-1:0] win_col;

    kp_state_t        state;
    kp_state_t        state_nxt;
    logic [ROW_W-1:0] row_idx;
    logic [ROW_W-1:0] row_idx_nxt;
    logic [COL_W-1:0] col_idx;
    logic [COL_W-1:0] col_idx_nxt;
    logic [CW-1:0]    db_cnt;
    logic [CW-1:0]    db_cnt_nxt;
    logic [CW-1:0]    db_cnt_inc;
    logic             accept;
    logic [ROWS-1:0]  row_n_nxt;
    logic             key_down_nxt;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .ck    (ck),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Columns are asynchronous to ck; two flops before any decision uses them.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= COL_IDLE_N;
            col_s <= COL_IDLE_N;
        end else begin
            col_m <= col_n;
            col_s <= col_m;
        end
    end

    assign any_pressed = (col_s != COL_IDLE_N);
    assign win_col     = first_low(col_s);
    assign db_cnt_inc  = db_cnt + CW'(1);

    // State register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCAN;
            row_idx  <= '0;
            col_idx  <= '0;
            db_cnt   <= '0;
            row_n    <= ROW_RST_N;
            key_down <= 1'b0;
        end else begin
            state    <= state_nxt;
            row_idx  <= row_idx_nxt;
            col_idx  <= col_idx_nxt;
            db_cnt   <= db_cnt_nxt;
            row_n    <= row_n_nxt;
            key_down <= key_down_nxt;
        end
    end

    // Next-state logic; the FSM only moves on scan ticks.
    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        col_idx_nxt = col_idx;
        db_cnt_nxt  = db_cnt;
        accept      = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (any_pressed) begin
                        col_idx_nxt = win_col;
                        db_cnt_nxt  = CW'(1);
                        state_nxt   = CONFIRM;
                    end else begin
                        row_idx_nxt = row_idx + ROW_W'(1);
                    end
                end
                CONFIRM: begin
                    // A different winning column counts as a bounce, not a new key.
                    if (any_pressed && (win_col == col_idx)) begin
                        db_cnt_nxt = db_cnt_inc;
                        if (db_cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            accept    = 1'b1;
                            state_nxt = HELD;
                        end
                    end else begin
                        state_nxt   = SCAN;
                        row_idx_nxt = row_idx + ROW_W'(1);
                    end
                end
                HELD: begin
                    if (!any_pressed) begin
                        db_cnt_nxt = CW'(1);
                        state_nxt  = RELEASE;
                    end
                end
                RELEASE: begin
                    if (any_pressed) begin
                        state_nxt = HELD;
                    end else begin
                        db_cnt_nxt = db_cnt_inc;
                        if (db_cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            state_nxt   = SCAN;
                            row_idx_nxt = row_idx + ROW_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    // Registered outputs follow the next state so they change with it.
    always_comb begin
        row_n_nxt    = row_drive(row_idx_nxt);
        key_down_nxt = (state_nxt == HELD) || (state_nxt == RELEASE);
    end

    // Key handshake runs every clock. An ack retires the current key; an accept
    // in the same cycle then reloads, so the consumer never sees a gap.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (key_valid && key_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
            if (accept) begin
                if (!key_valid || key_ack) begin
                    key_code  <= {row_idx, col_idx};
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a physical keypad model on row_n/col_n.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scan_ctrl;

    logic       ck;
    logic       rst_n;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;

    // Keypad model: a pressed key shorts its row to the columns in key_mask.
    logic       key_en;
    logic [1:0] key_row;
    logic [3:0] key_mask;

    int checks = 0;
    int errors = 0;

    keypad_scan_ctrl #(
        .TICK_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    always_comb begin
        col_n = 4'hF;
        if (key_en && (row_n[key_row] == 1'b0)) col_n = ~key_mask;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing on a falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge ck);
    endtask

    // One scan tick is four clocks.
    task automatic ticks(input int n);
        cyc(4 * n);
    endtask

    task automatic press(input logic [1:0] r, input logic [3:0] m);
        key_row  = r;
        key_mask = m;
        key_en   = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        key_ack  = 1'b0;
        key_en   = 1'b0;
        key_row  = 2'd0;
        key_mask = 4'h0;

        // Reset values and idle row walk.
        cyc(3);
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_valid", 4'(key_valid), 4'h0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_down", 4'(key_down), 4'h0);
        chk("rst_overrun", 4'(overrun), 4'h0);
        rst_n = 1'b1;
        ticks(1); chk("walk_r1", row_n, 4'b1101);
        ticks(1); chk("walk_r2", row_n, 4'b1011);
        ticks(1); chk("walk_r3", row_n, 4'b0111);
        ticks(1); chk("walk_r0", row_n, 4'b1110);
        chk("walk_valid", 4'(key_valid), 4'h0);

        // Bounce: row2/col1 seen for one tick only.
        press(2'd2, 4'b0010);
        ticks(3);
        chk("bounce_row_held", row_n, 4'b1011);
        chk("bounce_down", 4'(key_down), 4'h0);
        key_en = 1'b0;
        ticks(1);
        chk("bounce_resume_r3", row_n, 4'b0111);
        chk("bounce_valid", 4'(key_valid), 4'h0);

        // Held row2/col1 -> key 9.
        press(2'd2, 4'b0010);
        ticks(5);
        chk("hold_pre_valid", 4'(key_valid), 4'h0);
        ticks(1);
        chk("hold_valid", 4'(key_valid), 4'h1);
        chk("hold_code", key_code, 4'h9);
        chk("hold_down", 4'(key_down), 4'h1);
        chk("hold_row", row_n, 4'b1011);
        ticks(2);
        chk("hold_row_still", row_n, 4'b1011);
        key_en = 1'b0;
        ticks(2);
        chk("release_down_pending", 4'(key_down), 4'h1);
        chk("release_row_pending", row_n, 4'b1011);
        ticks(1);
        chk("release_down", 4'(key_down), 4'h0);
        chk("release_row_r3", row_n, 4'b0111);

        // Second key (row0/col3) with no ack -> overrun, code kept.
        press(2'd0, 4'b1000);
        ticks(3);
        chk("ovr_pre", 4'(overrun), 4'h0);
        ticks(1);
        chk("ovr_set", 4'(overrun), 4'h1);
        chk("ovr_code_kept", key_code, 4'h9);
        chk("ovr_valid", 4'(key_valid), 4'h1);
        key_ack = 1'b1; cyc(1); key_ack = 1'b0;
        chk("ack_valid_clr", 4'(key_valid), 4'h0);
        chk("ack_overrun_clr", 4'(overrun), 4'h0);
        cyc(3);
        // Ack with nothing pending is ignored.
        key_ack = 1'b1; cyc(1); key_ack = 1'b0;
        cyc(3);
        chk("idle_ack_valid", 4'(key_valid), 4'h0);
        chk("idle_ack_code", key_code, 4'h9);
        chk("idle_ack_down", 4'(key_down), 4'h1);
        key_en = 1'b0;
        ticks(3);
        chk("ovr_release_row", row_n, 4'b1101);

        // Row3/col0 -> key C, then row0/col3 accepted with ack on the same cycle.
        press(2'd3, 4'b0001);
        ticks(5);
        chk("keyc_code", key_code, 4'hC);
        chk("keyc_valid", 4'(key_valid), 4'h1);
        key_en = 1'b0;
        ticks(3);
        chk("keyc_release_row", row_n, 4'b1110);
        press(2'd0, 4'b1000);
        ticks(2);
        cyc(3);
        key_ack = 1'b1; cyc(1); key_ack = 1'b0;
        chk("same_cyc_code", key_code, 4'h3);
        chk("same_cyc_valid", 4'(key_valid), 4'h1);
        chk("same_cyc_overrun", 4'(overrun), 4'h0);
        key_en = 1'b0;
        ticks(3);
        chk("key3_release_row", row_n, 4'b1101);
        chk("key3_release_down", 4'(key_down), 4'h0);

        // Columns 1 and 2 low on row1 -> lowest column wins, key 5.
        press(2'd1, 4'b0110);
        key_ack = 1'b1; cyc(1); key_ack = 1'b0;
        cyc(3);
        chk("multi_pre_valid", 4'(key_valid), 4'h0);
        ticks(2);
        chk("multi_code", key_code, 4'h5);
        chk("multi_valid", 4'(key_valid), 4'h1);
        chk("multi_down", 4'(key_down), 4'h1);
        chk("multi_row", row_n, 4'b1101);
        ticks(1);

        // Asynchronous reset while HELD.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_row_n", row_n, 4'b1110);
        chk("arst_valid", 4'(key_valid), 4'h0);
        chk("arst_code", key_code, 4'h0);
        chk("arst_down", 4'(key_down), 4'h0);
        chk("arst_overrun", 4'(overrun), 4'h0);
        @(negedge ck);
        key_en = 1'b0;
        rst_n  = 1'b1;
        chk("post_rst_row", row_n, 4'b1110);
        ticks(1);
        chk("post_rst_walk", row_n, 4'b1101);
        chk("post_rst_valid", 4'(key_valid), 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
